// File: rtl/nvdla_dbb_axi_responder_if.sv
// rtl/nvdla_dbb_axi_responder_if.sv - dbb AXI channel bundle between the NVDLA core master and the responder
interface nvdla_dbb_axi_responder_if;
  logic        s_aw_awvalid;
  logic        s_aw_awready;
  logic [7:0]  s_aw_awid;
  logic [3:0]  s_aw_awlen;
  logic [63:0] s_aw_awaddr;

  logic        s_w_wvalid;
  logic        s_w_wready;
  logic [63:0] s_w_wdata;
  logic [7:0]  s_w_wstrb;
  logic        s_w_wlast;

  logic        s_b_bvalid;
  logic        s_b_bready;
  logic [7:0]  s_b_bid;
  logic [1:0]  s_b_bresp;

  logic        s_ar_arvalid;
  logic        s_ar_arready;
  logic [7:0]  s_ar_arid;
  logic [3:0]  s_ar_arlen;
  logic [63:0] s_ar_araddr;

  logic        s_r_rvalid;
  logic        s_r_rready;
  logic [7:0]  s_r_rid;
  logic        s_r_rlast;
  logic [63:0] s_r_rdata;
  logic [1:0]  s_r_rresp;

  modport master (
    output s_aw_awvalid, s_aw_awid, s_aw_awlen, s_aw_awaddr,
    output s_w_wvalid, s_w_wdata, s_w_wstrb, s_w_wlast,
    output s_b_bready,
    output s_ar_arvalid, s_ar_arid, s_ar_arlen, s_ar_araddr,
    output s_r_rready,
    input  s_aw_awready, s_w_wready, s_b_bvalid, s_b_bid, s_b_bresp,
    input  s_ar_arready, s_r_rvalid, s_r_rid, s_r_rlast, s_r_rdata, s_r_rresp
  );

  modport slave (
    input  s_aw_awvalid, s_aw_awid, s_aw_awlen, s_aw_awaddr,
    input  s_w_wvalid, s_w_wdata, s_w_wstrb, s_w_wlast,
    input  s_b_bready,
    input  s_ar_arvalid, s_ar_arid, s_ar_arlen, s_ar_araddr,
    input  s_r_rready,
    output s_aw_awready, s_w_wready, s_b_bvalid, s_b_bid, s_b_bresp,
    output s_ar_arready, s_r_rvalid, s_r_rid, s_r_rlast, s_r_rdata, s_r_rresp
  );
endinterface

// File: rtl/nvdla_dbb_axi_responder.sv
// rtl/nvdla_dbb_axi_responder.sv - memory-backed dbb AXI responder with independent write/read FSMs
// Define NVDLA_DBB_RESP_ERR_EN to answer out-of-range bursts with SLVERR instead of aliasing.
module nvdla_dbb_axi_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                     core_clk,
  input  logic                     rstn,
  nvdla_dbb_axi_responder_if.slave s
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [63:0] mem_q [DEPTH];

  w_state_e    w_state_q;
  logic        awready_q, wready_q, bvalid_q, w_err_q;
  logic [7:0]  bid_q;
  logic [1:0]  bresp_q;
  logic [3:0]  w_len_q, w_cnt_q;
  logic [AW-1:0] w_idx_q, w_idx_d;

  r_state_e    r_state_q;
  logic        arready_q, rvalid_q, rlast_q, r_err_q;
  logic [7:0]  rid_q;
  logic [1:0]  rresp_q;
  logic [63:0] rdata_q;
  logic [3:0]  r_len_q, r_cnt_q, r_cnt_d;
  logic [AW-1:0] r_idx_q, r_idx_d, ar_idx;

  logic aw_err, ar_err, w_fire, r_fire, unused_ok;

`ifdef NVDLA_DBB_RESP_ERR_EN
  assign aw_err    = |s.s_aw_awaddr[63:AW+3];
  assign ar_err    = |s.s_ar_araddr[63:AW+3];
  assign unused_ok = ^{s.s_w_wlast, s.s_aw_awaddr[2:0], s.s_ar_araddr[2:0]};
`else
  assign aw_err    = 1'b0;
  assign ar_err    = 1'b0;
  assign unused_ok = ^{s.s_w_wlast, s.s_aw_awaddr[2:0], s.s_ar_araddr[2:0],
                       s.s_aw_awaddr[63:AW+3], s.s_ar_araddr[63:AW+3]};
`endif

  assign w_fire  = (w_state_q == W_DATA) && s.s_w_wvalid && wready_q;
  assign r_fire  = rvalid_q && s.s_r_rready;
  assign w_idx_d = w_idx_q + AW'(1);
  assign r_idx_d = r_idx_q + AW'(1);
  assign r_cnt_d = r_cnt_q + 4'd1;
  assign ar_idx  = s.s_ar_araddr[AW+2:3];

  // Array is deliberately outside the reset domain; the read path samples it before this edge's write lands.
  always_ff @(posedge core_clk) begin
    if (w_fire && !w_err_q) begin
      for (int b = 0; b < 8; b++) begin
        if (s.s_w_wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= s.s_w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      w_err_q   <= 1'b0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_idx_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s.s_aw_awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s.s_aw_awid;
            w_len_q   <= s.s_aw_awlen;
            w_cnt_q   <= '0;
            w_idx_q   <= s.s_aw_awaddr[AW+2:3];
            w_err_q   <= aw_err;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          // Burst length alone terminates the data phase; wlast is not trusted.
          if (w_fire) begin
            w_cnt_q <= w_cnt_q + 4'd1;
            w_idx_q <= w_idx_d;
            if (w_cnt_q == w_len_q) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= w_err_q ? 2'b10 : 2'b00;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s.s_b_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      r_err_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s.s_ar_arvalid && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= s.s_ar_arid;
            r_len_q   <= s.s_ar_arlen;
            r_cnt_q   <= '0;
            rlast_q   <= (s.s_ar_arlen == 4'd0);
            r_err_q   <= ar_err;
            rresp_q   <= ar_err ? 2'b10 : 2'b00;
            rdata_q   <= ar_err ? 64'd0 : mem_q[ar_idx];
            r_idx_q   <= ar_idx + AW'(1);
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          // r_idx_q already points at the beat after the one being presented.
          if (r_fire) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              rdata_q <= r_err_q ? 64'd0 : mem_q[r_idx_q];
              r_idx_q <= r_idx_d;
              r_cnt_q <= r_cnt_d;
              rlast_q <= (r_cnt_d == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s.s_aw_awready = awready_q;
  assign s.s_w_wready   = wready_q;
  assign s.s_b_bvalid   = bvalid_q;
  assign s.s_b_bid      = bid_q;
  assign s.s_b_bresp    = bresp_q;
  assign s.s_ar_arready = arready_q;
  assign s.s_r_rvalid   = rvalid_q;
  assign s.s_r_rid      = rid_q;
  assign s.s_r_rlast    = rlast_q;
  assign s.s_r_rdata    = rdata_q;
  assign s.s_r_rresp    = rresp_q;
endmodule
